// File: rtl/pe_bus_interconnect_pkg.sv
// rtl/pe_bus_interconnect_pkg.sv - shared types and region helper for the PE bus interconnect
package pe_bus_interconnect_pkg;

    typedef enum logic [2:0] {SEL_NONE, SEL_RAM, SEL_PLIC, SEL_RTC, SEL_NI} bus_sel_e;
    typedef enum logic {ARB_NORMAL, ARB_CPU_PRIO} arb_state_e;

    localparam int REGION_BITS = 16;

    function automatic logic region_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:REGION_BITS] == base[31:REGION_BITS];
    endfunction

endpackage

// File: rtl/pe_ram_arbiter.sv
// rtl/pe_ram_arbiter.sv - CPU/DMA data-RAM arbiter with DMA burst limit
module pe_ram_arbiter
    import pe_bus_interconnect_pkg::*;
#(
    parameter int DMA_BURST_MAX = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cpu_ram_req_i,
    input  logic dma_req_i,
    output logic dma_owner_o,
    output logic dma_grant_o,
    output logic cpu_stall_o
);

    localparam logic [7:0] LP_LAST_STALL = 8'(DMA_BURST_MAX - 2);

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic [7:0] r_starve_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ARB_NORMAL;
            r_starve_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= cpu_stall_o ? r_starve_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        dma_owner_o  = 1'b0;
        dma_grant_o  = 1'b0;
        cpu_stall_o  = 1'b0;
        w_state_next = ARB_NORMAL;

        dma_owner_o = dma_req_i && !(r_state == ARB_CPU_PRIO && cpu_ram_req_i);
        dma_grant_o = dma_req_i && dma_owner_o;
        cpu_stall_o = cpu_ram_req_i && dma_owner_o;

        // The stalled cycle now in progress is the (DMA_BURST_MAX-1)th: hand the next one to the CPU
        if (r_state == ARB_NORMAL && cpu_stall_o && r_starve_cnt == LP_LAST_STALL)
            w_state_next = ARB_CPU_PRIO;
    end

endmodule

// File: rtl/pe_bus_interconnect.sv
// rtl/pe_bus_interconnect.sv - RS5 data-port decode, read return and RAM sharing with DMNI DMA
// Optional bus-error reporting and err_addr_q readback are enabled with PE_BUS_ERR_EN.
module pe_bus_interconnect
    import pe_bus_interconnect_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE     = 32'h8000_0000,
    parameter logic [31:0] RTC_BASE      = 32'h8001_0000,
    parameter logic [31:0] NI_BASE       = 32'h8002_0000,
    parameter logic [31:0] RAM_LIMIT     = 32'h0010_0000,
    parameter int          DMA_BURST_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_en_i,
    input  logic [3:0]  cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_stall_o,
    input  logic        dma_en_i,
    input  logic [3:0]  dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_data_i,
    output logic        dma_grant_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_data_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        plic_en_o,
    output logic        rtc_en_o,
    output logic        ni_en_o,
    input  logic [31:0] plic_data_i,
    input  logic [31:0] rtc_data_i,
    input  logic [31:0] ni_data_i
`ifdef PE_BUS_ERR_EN
    ,
    output logic        err_irq_o
`endif
);

    // Requests are masked during reset so every enable, grant and stall reads 0
    logic     w_cpu_en;
    logic     w_dma_en;
    bus_sel_e w_sel;
    bus_sel_e r_sel;
    logic     w_cpu_ram_req;
    logic     w_dma_owner;
    logic     w_accept;
    logic     w_err_rd;
    logic     r_dma_rvalid;

    assign w_cpu_en = cpu_en_i & rst_ni;
    assign w_dma_en = dma_en_i & rst_ni;

    always_comb begin
        w_sel = SEL_NONE;
        if (cpu_addr_i < RAM_LIMIT)                w_sel = SEL_RAM;
        else if (region_hit(cpu_addr_i, PLIC_BASE)) w_sel = SEL_PLIC;
        else if (region_hit(cpu_addr_i, RTC_BASE))  w_sel = SEL_RTC;
        else if (region_hit(cpu_addr_i, NI_BASE))   w_sel = SEL_NI;
    end

`ifdef PE_BUS_ERR_EN
    assign w_err_rd = (cpu_addr_i == (NI_BASE | 32'h0000_FFFC));
`else
    assign w_err_rd = 1'b0;
`endif

    assign w_cpu_ram_req = w_cpu_en && (w_sel == SEL_RAM);

    pe_ram_arbiter #(
        .DMA_BURST_MAX (DMA_BURST_MAX)
    ) u_arbiter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cpu_ram_req_i (w_cpu_ram_req),
        .dma_req_i     (w_dma_en),
        .dma_owner_o   (w_dma_owner),
        .dma_grant_o   (dma_grant_o),
        .cpu_stall_o   (cpu_stall_o)
    );

    assign w_accept  = w_cpu_en && !cpu_stall_o;
    assign plic_en_o = w_cpu_en && (w_sel == SEL_PLIC);
    assign rtc_en_o  = w_cpu_en && (w_sel == SEL_RTC);
    assign ni_en_o   = w_cpu_en && (w_sel == SEL_NI) && !w_err_rd;

    assign mem_en_o   = w_dma_owner ? dma_grant_o : w_cpu_ram_req;
    assign mem_we_o   = mem_en_o ? (w_dma_owner ? dma_we_i : cpu_we_i) : 4'd0;
    assign mem_addr_o = w_dma_owner ? dma_addr_i : cpu_addr_i;
    assign mem_data_o = w_dma_owner ? dma_data_i : cpu_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel        <= SEL_NONE;
            r_dma_rvalid <= 1'b0;
        end else begin
            if (w_accept) r_sel <= w_sel;
            r_dma_rvalid <= dma_grant_o && (dma_we_i == 4'd0);
        end
    end

    assign dma_rvalid_o = r_dma_rvalid;
    assign dma_data_o   = mem_data_i;

`ifdef PE_BUS_ERR_EN
    logic        r_err_irq;
    logic        r_err_rd;
    logic [31:0] r_err_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_irq  <= 1'b0;
            r_err_rd   <= 1'b0;
            r_err_addr <= 32'd0;
        end else begin
            r_err_irq <= w_accept && (w_sel == SEL_NONE);
            if (w_accept) r_err_rd <= w_err_rd;
            if (w_accept && w_sel == SEL_NONE) r_err_addr <= cpu_addr_i;
        end
    end

    assign err_irq_o = r_err_irq;
`endif

    always_comb begin
        cpu_data_o = 32'd0;
        case (r_sel)
            SEL_RAM:  cpu_data_o = mem_data_i;
            SEL_PLIC: cpu_data_o = plic_data_i;
            SEL_RTC:  cpu_data_o = rtc_data_i;
            SEL_NI:   cpu_data_o = ni_data_i;
            default:  cpu_data_o = 32'd0;
        endcase
`ifdef PE_BUS_ERR_EN
        if (r_sel == SEL_NI && r_err_rd) cpu_data_o = r_err_addr;
`endif
    end

endmodule

// File: tb/tb_pe_bus_interconnect.sv
// tb/tb_pe_bus_interconnect.sv - directed self-checking bench for pe_bus_interconnect
module tb_pe_bus_interconnect;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_en_i;
    logic [3:0]  cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stall_o;
    logic        dma_en_i;
    logic [3:0]  dma_we_i;
    logic [31:0] dma_addr_i;
    logic [31:0] dma_data_i;
    logic        dma_grant_o;
    logic        dma_rvalid_o;
    logic [31:0] dma_data_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        plic_en_o;
    logic        rtc_en_o;
    logic        ni_en_o;
    logic [31:0] plic_data_i;
    logic [31:0] rtc_data_i;
    logic [31:0] ni_data_i;
`ifdef PE_BUS_ERR_EN
    logic        err_irq_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    pe_bus_interconnect dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cpu_en_i     (cpu_en_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .dma_en_i     (dma_en_i),
        .dma_we_i     (dma_we_i),
        .dma_addr_i   (dma_addr_i),
        .dma_data_i   (dma_data_i),
        .dma_grant_o  (dma_grant_o),
        .dma_rvalid_o (dma_rvalid_o),
        .dma_data_o   (dma_data_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .plic_en_o    (plic_en_o),
        .rtc_en_o     (rtc_en_o),
        .ni_en_o      (ni_en_o),
        .plic_data_i  (plic_data_i),
        .rtc_data_i   (rtc_data_i),
        .ni_data_i    (ni_data_i)
`ifdef PE_BUS_ERR_EN
        ,
        .err_irq_o    (err_irq_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
        cpu_en_i   = en;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
    endtask

    task automatic set_dma(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
        dma_en_i   = en;
        dma_we_i   = we;
        dma_addr_i = addr;
        dma_data_i = data;
    endtask

    task automatic chk_no_periph(input string tag);
        chk({tag, "_plic_en"}, 32'(plic_en_o), 32'd0);
        chk({tag, "_rtc_en"},  32'(rtc_en_o),  32'd0);
        chk({tag, "_ni_en"},   32'(ni_en_o),   32'd0);
    endtask

    // CPU RAM read at 0x200 against a DMA read at 0x400: 7 stalled DMA cycles, then one CPU cycle
    task automatic starve(input int n);
        logic prev_grant;
        logic exp_dma;
        prev_grant = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_dma = ((k % 8) != 7);
            #2;
            chk($sformatf("starve%0d_stall", k),  32'(cpu_stall_o),  32'(exp_dma));
            chk($sformatf("starve%0d_grant", k),  32'(dma_grant_o),  32'(exp_dma));
            chk($sformatf("starve%0d_addr", k),   mem_addr_o,        exp_dma ? 32'h0000_0400 : 32'h0000_0200);
            chk($sformatf("starve%0d_rvalid", k), 32'(dma_rvalid_o), 32'(prev_grant));
            prev_grant = exp_dma;
            @(negedge clk_i);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        mem_data_i  = 32'hDEAD_BEEF;
        plic_data_i = 32'h0000_0A0A;
        rtc_data_i  = 32'h0000_1234;
        ni_data_i   = 32'h0000_5555;
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);

        chk("rst_stall",   32'(cpu_stall_o),  32'd0);
        chk("rst_grant",   32'(dma_grant_o),  32'd0);
        chk("rst_rvalid",  32'(dma_rvalid_o), 32'd0);
        chk("rst_rdata",   cpu_data_o,        32'd0);
        chk("rst_mem_en",  32'(mem_en_o),     32'd0);
        chk_no_periph("rst");
`ifdef PE_BUS_ERR_EN
        chk("rst_err_irq", 32'(err_irq_o),    32'd0);
`endif
        rst_ni = 1'b1;

        // CPU RAM read, DMA idle
        @(negedge clk_i);
        set_cpu(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        #2;
        chk("ram_rd_mem_en", 32'(mem_en_o),    32'd1);
        chk("ram_rd_stall",  32'(cpu_stall_o), 32'd0);
        chk("ram_rd_addr",   mem_addr_o,       32'h0000_0100);
        chk("ram_rd_we",     32'(mem_we_o),    32'd0);
        chk_no_periph("ram_rd");

        // RTC read; the RAM read data returns in this same cycle
        @(negedge clk_i);
        chk("ram_rd_data", cpu_data_o, 32'hDEAD_BEEF);
        set_cpu(1'b1, 4'h0, 32'h8001_0004, 32'h0);
        #2;
        chk("rtc_rd_rtc_en",  32'(rtc_en_o),  32'd1);
        chk("rtc_rd_plic_en", 32'(plic_en_o), 32'd0);
        chk("rtc_rd_ni_en",   32'(ni_en_o),   32'd0);
        chk("rtc_rd_mem_en",  32'(mem_en_o),  32'd0);
        @(negedge clk_i);
        chk("rtc_rd_data", cpu_data_o, 32'h0000_1234);

        // DMA starvation pattern, two full periods
        set_cpu(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        set_dma(1'b1, 4'h0, 32'h0000_0400, 32'h0);
        starve(16);
        chk("starve_cpu_data", cpu_data_o, 32'hDEAD_BEEF);

        // DMA RAM write alongside CPU write to the NI region
        set_cpu(1'b1, 4'hF, 32'h8002_0008, 32'hCAFE_0001);
        set_dma(1'b1, 4'h3, 32'h0000_0040, 32'h1357_9BDF);
        #2;
        chk("simul_mem_we",   32'(mem_we_o),    32'h3);
        chk("simul_mem_en",   32'(mem_en_o),    32'd1);
        chk("simul_mem_data", mem_data_o,       32'h1357_9BDF);
        chk("simul_ni_en",    32'(ni_en_o),     32'd1);
        chk("simul_stall",    32'(cpu_stall_o), 32'd0);
        chk("simul_grant",    32'(dma_grant_o), 32'd1);
        @(negedge clk_i);
        chk("simul_rvalid",   32'(dma_rvalid_o), 32'd0);

        // Reset in the middle of a starvation burst with a DMA read outstanding
        set_cpu(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        set_dma(1'b1, 4'h0, 32'h0000_0400, 32'h0);
        starve(3);
        chk("pre_rst_rdata", cpu_data_o, 32'h0000_5555);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(dma_rvalid_o), 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en_o),     32'd0);
        chk("mid_rst_stall",  32'(cpu_stall_o),  32'd0);
        chk("mid_rst_grant",  32'(dma_grant_o),  32'd0);
        chk("mid_rst_rdata",  cpu_data_o,        32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        starve(8);

        // Unmapped write, then unmapped read
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        set_cpu(1'b1, 4'h0, 32'h8000_0010, 32'h0);
        #2;
        chk("plic_rd_plic_en", 32'(plic_en_o), 32'd1);
        @(negedge clk_i);
        set_cpu(1'b1, 4'hF, 32'hA000_0000, 32'h1111_1111);
        #2;
        chk("unmap_wr_prev_data", cpu_data_o,        32'h0000_0A0A);
        chk("unmap_wr_mem_en",    32'(mem_en_o),     32'd0);
        chk("unmap_wr_mem_we",    32'(mem_we_o),     32'd0);
        chk("unmap_wr_stall",     32'(cpu_stall_o),  32'd0);
        chk_no_periph("unmap_wr");
        @(negedge clk_i);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        chk("unmap_wr_data", cpu_data_o, 32'd0);
`ifdef PE_BUS_ERR_EN
        chk("unmap_wr_irq", 32'(err_irq_o), 32'd1);
`endif
        @(negedge clk_i);
`ifdef PE_BUS_ERR_EN
        chk("idle_irq", 32'(err_irq_o), 32'd0);
`endif
        set_cpu(1'b1, 4'h0, 32'h9000_0000, 32'h0);
        #2;
        chk("unmap_rd_mem_en", 32'(mem_en_o), 32'd0);
        chk_no_periph("unmap_rd");
        @(negedge clk_i);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        chk("unmap_rd_data", cpu_data_o, 32'd0);
`ifdef PE_BUS_ERR_EN
        chk("unmap_rd_irq", 32'(err_irq_o), 32'd1);
        @(negedge clk_i);
        chk("unmap_rd_irq_end", 32'(err_irq_o), 32'd0);
        set_cpu(1'b1, 4'h0, 32'h8002_FFFC, 32'h0);
        #2;
        chk("err_rd_ni_en", 32'(ni_en_o), 32'd0);
        @(negedge clk_i);
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        chk("err_rd_data", cpu_data_o, 32'h9000_0000);
        chk("err_rd_irq",  32'(err_irq_o), 32'd0);
`endif

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
